// File: rtl/adder_rc_pipe_if.sv
// Operand/result bundle for the pipelined ripple-carry adder.
// The master drives operands and accepts results; the slave is the adder.
interface adder_rc_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   S;
    logic             Ovf;

    modport master (
        output in_valid, A, B, Ci, out_ready,
        input  in_ready, out_valid, S, Ovf
    );

    modport slave (
        input  in_valid, A, B, Ci, out_ready,
        output in_ready, out_valid, S, Ovf
    );
endinterface

// File: rtl/adder_rc_pipe.sv
// Pipelined ripple-carry adder: WIDTH bits split into STAGES chunks, one chunk per
// stage, carry registered between stages, single global stall from the output side.
module adder_rc_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    adder_rc_pipe_if.slave bus
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int PREV  = (STAGES > 1) ? STAGES - 2 : 0;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("adder_rc_pipe: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    logic             valid_q [STAGES];
    logic             carry_q [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic             ovf_q;

    logic             valid_d [STAGES];
    logic             carry_d [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic [CHUNK:0]   part_d  [STAGES];
    logic             ovf_d;
    logic             adv;

    assign adv = !valid_q[STAGES-1] || bus.out_ready;

    always_comb begin
        ovf_d = ovf_q;
        for (int k = 0; k < STAGES; k++) begin
            valid_d[k] = valid_q[k];
            carry_d[k] = carry_q[k];
            sum_d[k]   = sum_q[k];
            a_d[k]     = a_q[k];
            b_d[k]     = b_q[k];
            part_d[k]  = '0;
        end

        part_d[0]              = {1'b0, bus.A[CHUNK-1:0]} + {1'b0, bus.B[CHUNK-1:0]}
                               + (CHUNK+1)'(bus.Ci);
        valid_d[0]             = bus.in_valid && adv;
        carry_d[0]             = part_d[0][CHUNK];
        sum_d[0]               = '0;
        sum_d[0][CHUNK-1:0]    = part_d[0][CHUNK-1:0];
        a_d[0]                 = bus.A;
        b_d[0]                 = bus.B;

        // Operands travel whole so each stage can pick its own chunk at the right time.
        for (int k = 1; k < STAGES; k++) begin
            part_d[k]                 = {1'b0, a_q[k-1][k*CHUNK +: CHUNK]}
                                      + {1'b0, b_q[k-1][k*CHUNK +: CHUNK]}
                                      + (CHUNK+1)'(carry_q[k-1]);
            valid_d[k]                = valid_q[k-1];
            carry_d[k]                = part_d[k][CHUNK];
            sum_d[k]                  = sum_q[k-1];
            sum_d[k][k*CHUNK +: CHUNK] = part_d[k][CHUNK-1:0];
            a_d[k]                    = a_q[k-1];
            b_d[k]                    = b_q[k-1];
        end

        // Overflow is resolved alongside the last chunk, where the sum MSB appears.
        if (STAGES == 1) begin
            ovf_d = (bus.A[WIDTH-1] == bus.B[WIDTH-1])
                 && (part_d[0][CHUNK-1] != bus.A[WIDTH-1]);
        end else begin
            ovf_d = (a_q[PREV][WIDTH-1] == b_q[PREV][WIDTH-1])
                 && (part_d[STAGES-1][CHUNK-1] != a_q[PREV][WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                sum_q[k]   <= '0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_d[k];
                carry_q[k] <= carry_d[k];
                sum_q[k]   <= sum_d[k];
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.S         = {carry_q[STAGES-1], sum_q[STAGES-1]};
    assign bus.Ovf       = ovf_q;
endmodule

// File: tb/tb_adder_rc_pipe.sv
// Scoreboard bench for adder_rc_pipe: default-size streaming tests plus a small
// parameter sweep of extra instances checking the all-ones corner and latency.
module tb_adder_rc_pipe;
    localparam int W  = 32;
    localparam int ST = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sw_w(input int i);
        case (i)
            0:       return 9;
            1:       return 9;
            2:       return 16;
            default: return 64;
        endcase
    endfunction

    function automatic int sw_s(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            2:       return 16;
            default: return 8;
        endcase
    endfunction

    adder_rc_pipe_if #(.WIDTH(W)) bus ();
    adder_rc_pipe #(.WIDTH(W), .STAGES(ST)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [W+1:0] sb_q [$];
    logic [ST-1:0] hist;
    logic          lat_chk;
    logic          stalled;
    logic [W+1:0]  held;

    // One cycle: drive at negedge, evaluate transfers just before the next posedge.
    task automatic cycle(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic ordy);
        logic         acc;
        logic [W:0]   ref_s;
        logic [W+1:0] exp_v;
        bus.in_valid  = iv;
        bus.A         = a;
        bus.B         = b;
        bus.Ci        = ci;
        bus.out_ready = ordy;
        #1;
        acc = iv && bus.in_ready;
        if (lat_chk) check("valid_pattern", bus.out_valid, hist[ST-1]);
        hist = {hist[ST-2:0], acc};
        if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out", bus.out_valid, 1'b0);
            end else begin
                exp_v = sb_q.pop_front();
                check("result", {bus.S, bus.Ovf}, exp_v);
                $display("[TB] out S=%0h Ovf=%0b", bus.S, bus.Ovf);
            end
            stalled = 1'b0;
        end else if (bus.out_valid) begin
            if (stalled) check("stall_hold", {bus.S, bus.Ovf}, held);
            check("stall_in_ready", bus.in_ready, 1'b0);
            held    = {bus.S, bus.Ovf};
            stalled = 1'b1;
        end else begin
            stalled = 1'b0;
        end
        if (acc) begin
            ref_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            exp_v = {ref_s, (a[W-1] == b[W-1]) && (ref_s[W-1] != a[W-1])};
            sb_q.push_back(exp_v);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb_q.size() > 0; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
        check("drain_empty", sb_q.size(), 0);
    endtask

    for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
        localparam int GW = sw_w(gi);
        localparam int GS = sw_s(gi);
        logic done = 1'b0;
        adder_rc_pipe_if #(.WIDTH(GW)) sbus ();
        adder_rc_pipe #(.WIDTH(GW), .STAGES(GS)) sdut (.clk(clk), .rst_n(rst_n), .bus(sbus));

        initial begin
            int          cnt;
            logic [GW:0] ones_s;
            sbus.in_valid  = 1'b0;
            sbus.A         = '0;
            sbus.B         = '0;
            sbus.Ci        = 1'b0;
            sbus.out_ready = 1'b1;
            ones_s         = '1;
            wait (rst_n === 1'b1);
            @(negedge clk);
            sbus.in_valid = 1'b1;
            sbus.A        = '1;
            sbus.B        = '1;
            sbus.Ci       = 1'b1;
            cnt = 0;
            do begin
                @(posedge clk);
                #1;
                sbus.in_valid = 1'b0;
                cnt++;
            end while (!sbus.out_valid && cnt < 40);
            check($sformatf("sweep%0d_latency", gi), cnt, GS);
            check($sformatf("sweep%0d_sum", gi), {sbus.S, sbus.Ovf}, {ones_s, 1'b0});
            $display("[TB] sweep W=%0d ST=%0d S=%0h Ovf=%0b latency=%0d", GW, GS, sbus.S, sbus.Ovf, cnt);
            done = 1'b1;
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Ci        = 1'b0;
        bus.out_ready = 1'b1;
        hist          = '0;
        lat_chk       = 1'b0;
        stalled       = 1'b0;
        held          = '0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_S", bus.S, '0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);

        // Carry ripple through all chunks, then signed overflow, then a random stream.
        lat_chk = 1'b1;
        cycle(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
        cycle(1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
        repeat (100) cycle(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);

        // Backpressure with the pipeline full, then release.
        lat_chk = 1'b0;
        repeat (5) cycle(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
        repeat (6) cycle(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
        drain();

        // Random bubbles: out_valid must follow in_valid delayed by ST cycles.
        hist    = '0;
        lat_chk = 1'b1;
        repeat (60) cycle(1'($urandom_range(0, 1)), $urandom, $urandom,
                          1'($urandom_range(0, 1)), 1'b1);
        drain();

        // Reset with work in flight: nothing may emerge afterwards.
        repeat (3) cycle(1'b1, $urandom, $urandom, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_S", {bus.S, bus.Ovf}, '0);
        sb_q.delete();
        hist    = '0;
        stalled = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) cycle(1'b0, '0, '0, 1'b0, 1'b1);

        for (int i = 0; i < 200 && !(g_sweep[0].done && g_sweep[1].done &&
                                    g_sweep[2].done && g_sweep[3].done); i++)
            @(negedge clk);
        check("sweeps_done", {g_sweep[3].done, g_sweep[2].done, g_sweep[1].done, g_sweep[0].done},
              4'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
